// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register-file write port between ALU and load writeback sources.
// Each source is buffered in its own FIFO; heads are drained round-robin, with age order kept for same-register writes.
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req0_valid,
    output logic                         req0_ready,
    input  logic [ADDR_WIDTH-1:0]        req0_addr,
    input  logic [DATA_WIDTH-1:0]        req0_data,
    input  logic                         req1_valid,
    output logic                         req1_ready,
    input  logic [ADDR_WIDTH-1:0]        req1_addr,
    input  logic [DATA_WIDTH-1:0]        req1_data,
    output logic                         reg_wr,
    output logic [ADDR_WIDTH-1:0]        address_rd,
    output logic [DATA_WIDTH-1:0]        data_wr,
    output logic [(1<<ADDR_WIDTH)-1:0]   pending_mask
);

    localparam int PW = $clog2(DEPTH);

    typedef enum logic {FAV_REQ0, FAV_REQ1} rr_e;

    // Per-source FIFO storage and control, indexed [source][slot]
    logic [ADDR_WIDTH-1:0] fifo_addr_q  [2][DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data_q  [2][DEPTH];
    logic [2:0]            fifo_stamp_q [2][DEPTH];
    logic [DEPTH-1:0]      vld_q        [2];
    logic [DEPTH-1:0]      vld_d        [2];
    logic [PW-1:0]         wptr_q       [2];
    logic [PW-1:0]         rptr_q       [2];
    logic [2:0]            stamp_q;
    logic [2:0]            stamp_d;
    rr_e                   rr_q;

    logic [ADDR_WIDTH-1:0] in_addr    [2];
    logic [DATA_WIDTH-1:0] in_data    [2];
    logic [2:0]            push_stamp [2];
    logic [ADDR_WIDTH-1:0] head_addr  [2];
    logic [DATA_WIDTH-1:0] head_data  [2];
    logic [2:0]            head_stamp [2];
    logic [1:0]            in_valid;
    logic [1:0]            full;
    logic [1:0]            push;
    logic [1:0]            head_v;
    logic [1:0]            gnt;
    logic [2:0]            age_diff;

    always_comb begin
        in_valid   = {req1_valid, req0_valid};
        in_addr[0] = req0_addr;
        in_addr[1] = req1_addr;
        in_data[0] = req0_data;
        in_data[1] = req1_data;
        for (int unsigned s = 0; s < 2; s++) begin
            full[s]       = &vld_q[s];
            push[s]       = in_valid[s] && !full[s];
            head_v[s]     = vld_q[s][rptr_q[s]];
            head_addr[s]  = fifo_addr_q[s][rptr_q[s]];
            head_data[s]  = fifo_data_q[s][rptr_q[s]];
            head_stamp[s] = fifo_stamp_q[s][rptr_q[s]];
        end
        req0_ready = !full[0];
        req1_ready = !full[1];
    end

    // When both push together, req0 takes the current stamp so it ranks older
    always_comb begin
        push_stamp[0] = stamp_q;
        push_stamp[1] = stamp_q + 3'(push[0]);
        stamp_d       = stamp_q + 3'(push[0]) + 3'(push[1]);
    end

    always_comb begin
        gnt      = '0;
        age_diff = head_stamp[0] - head_stamp[1];
        if (head_v[0] && head_v[1]) begin
            if (head_addr[0] == head_addr[1]) begin
                if (age_diff[2]) gnt[0] = 1'b1;
                else             gnt[1] = 1'b1;
            end else if (rr_q == FAV_REQ0) begin
                gnt[0] = 1'b1;
            end else begin
                gnt[1] = 1'b1;
            end
        end else if (head_v[0]) begin
            gnt[0] = 1'b1;
        end else if (head_v[1]) begin
            gnt[1] = 1'b1;
        end
    end

    // A full FIFO never pushes, so the pop slot and push slot cannot collide
    always_comb begin
        for (int unsigned s = 0; s < 2; s++) begin
            vld_d[s] = vld_q[s];
            if (gnt[s])  vld_d[s][rptr_q[s]] = 1'b0;
            if (push[s]) vld_d[s][wptr_q[s]] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned s = 0; s < 2; s++) begin
            if (push[s]) begin
                fifo_addr_q[s][wptr_q[s]]  <= in_addr[s];
                fifo_data_q[s][wptr_q[s]]  <= in_data[s];
                fifo_stamp_q[s][wptr_q[s]] <= push_stamp[s];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned s = 0; s < 2; s++) begin
                vld_q[s]  <= '0;
                wptr_q[s] <= '0;
                rptr_q[s] <= '0;
            end
            stamp_q    <= '0;
            rr_q       <= FAV_REQ0;
            reg_wr     <= 1'b0;
            address_rd <= '0;
            data_wr    <= '0;
        end else begin
            for (int unsigned s = 0; s < 2; s++) begin
                vld_q[s] <= vld_d[s];
                if (push[s]) wptr_q[s] <= wptr_q[s] + PW'(1);
                if (gnt[s])  rptr_q[s] <= rptr_q[s] + PW'(1);
            end
            stamp_q <= stamp_d;
            reg_wr  <= |gnt;
            if (gnt[0]) begin
                rr_q       <= FAV_REQ1;
                address_rd <= head_addr[0];
                data_wr    <= head_data[0];
            end else if (gnt[1]) begin
                rr_q       <= FAV_REQ0;
                address_rd <= head_addr[1];
                data_wr    <= head_data[1];
            end
        end
    end

    always_comb begin
        pending_mask = '0;
        for (int unsigned s = 0; s < 2; s++) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (vld_q[s][i]) pending_mask[fifo_addr_q[s][i]] = 1'b1;
            end
        end
        if (reg_wr) pending_mask[address_rd] = 1'b1;
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed bench for regfile_wb_arbiter against a queue-based writeback model.
module tb_regfile_wb_arbiter;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req1_valid;
    logic          req0_ready, req1_ready;
    logic [AW-1:0] req0_addr, req1_addr;
    logic [DW-1:0] req0_data, req1_data;
    logic          reg_wr;
    logic [AW-1:0] address_rd;
    logic [DW-1:0] data_wr;
    logic [15:0]   pending_mask;

    regfile_wb_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
        .reg_wr(reg_wr), .address_rd(address_rd), .data_wr(data_wr), .pending_mask(pending_mask)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model: each source is a queue of pending writes tagged with an unbounded push sequence number
    typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; int seq; } ent_t;
    typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
    ent_t q0[$];
    ent_t q1[$];
    int   seq  = 0;
    int   m_rr = 0;
    logic          m_wr   = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0;
    wr_t  wlog[$];
    logic [DW-1:0] rf [16];

    always @(posedge clk) begin : model
        int g;
        bit r0, r1;
        if (rst) begin
            q0.delete(); q1.delete();
            m_rr = 0; m_wr = 1'b0; m_addr = '0; m_data = '0;
        end else begin
            r0 = q0.size() < DEPTH;
            r1 = q1.size() < DEPTH;
            g = -1;
            if (q0.size() > 0 && q1.size() > 0) begin
                if (q0[0].addr == q1[0].addr) g = (q0[0].seq < q1[0].seq) ? 0 : 1;
                else                          g = m_rr;
            end else if (q0.size() > 0) g = 0;
            else if (q1.size() > 0)     g = 1;
            m_wr = (g >= 0);
            if (g == 0) begin
                m_addr = q0[0].addr; m_data = q0[0].data; void'(q0.pop_front()); m_rr = 1;
            end else if (g == 1) begin
                m_addr = q1[0].addr; m_data = q1[0].data; void'(q1.pop_front()); m_rr = 0;
            end
            if (req0_valid && r0) begin q0.push_back('{req0_addr, req0_data, seq}); seq++; end
            if (req1_valid && r1) begin q1.push_back('{req1_addr, req1_data, seq}); seq++; end
        end
    end

    always @(negedge clk) begin : compare
        logic [15:0] em;
        em = '0;
        foreach (q0[i]) em[q0[i].addr] = 1'b1;
        foreach (q1[i]) em[q1[i].addr] = 1'b1;
        if (m_wr) em[m_addr] = 1'b1;
        chk("req0_ready", req0_ready, q0.size() < DEPTH);
        chk("req1_ready", req1_ready, q1.size() < DEPTH);
        chk("reg_wr", reg_wr, m_wr);
        chk("address_rd", address_rd, m_addr);
        chk("data_wr", data_wr, m_data);
        chk("pending_mask", pending_mask, em);
        if (reg_wr === 1'b1) begin
            wlog.push_back('{address_rd, data_wr});
            rf[address_rd] = data_wr;
        end
    end

    task automatic step();
        @(negedge clk); #1;
    endtask

    task automatic idle();
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1; step(); step(); rst = 1'b0;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : driver
        int run, max_run, nwr, n10, idx;
        logic [AW-1:0] seen [$];
        logic r1_seen [4];
        logic [DW-1:0] first7;
        bit got7;

        rst = 1'b1; idle();
        req0_addr = '0; req1_addr = '0; req0_data = '0; req1_data = '0;
        step(); step(); rst = 1'b0;

        // Reset state
        chk("t1_reg_wr", reg_wr, 1'b0);
        chk("t1_ready0", req0_ready, 1'b1);
        chk("t1_ready1", req1_ready, 1'b1);
        chk("t1_mask", pending_mask, 16'h0000);

        // Single ALU write
        do_reset();
        req0_valid = 1'b1; req0_addr = 4'd5; req0_data = 32'hDEADBEEF;
        step(); idle();
        chk("t2_wr_before", reg_wr, 1'b0);
        chk("t2_mask_buffered", pending_mask, 16'h0020);
        step();
        chk("t2_wr", reg_wr, 1'b1);
        chk("t2_addr", address_rd, 4'd5);
        chk("t2_data", data_wr, 32'hDEADBEEF);
        chk("t2_mask_port", pending_mask, 16'h0020);
        step();
        chk("t2_wr_after", reg_wr, 1'b0);
        chk("t2_mask_after", pending_mask, 16'h0000);

        // Continuous contention with distinct addresses
        do_reset();
        run = 0; max_run = 0;
        for (int c = 0; c < 14; c++) begin
            req0_valid = 1'b1; req0_addr = 4'd3; req0_data = $urandom;
            req1_valid = 1'b1; req1_addr = 4'd4; req1_data = $urandom;
            step();
            if (!req0_ready && !req1_ready) run++; else run = 0;
            if (run > max_run) max_run = run;
            if (reg_wr) seen.push_back(address_rd);
        end
        idle();
        chk("t3_nwrites", seen.size() >= 10, 1'b1);
        foreach (seen[k]) chk("t3_alternate", seen[k], (k % 2 == 0) ? 4'd3 : 4'd4);
        chk("t3_ready_starve", max_run <= DEPTH, 1'b1);
        repeat (6) step();

        // Same-register writes pushed together while RR favours req1
        do_reset();
        wlog.delete();
        req0_valid = 1'b1; req0_addr = 4'd1; req0_data = 32'h0000_00AA;
        step();
        req0_addr = 4'd7; req0_data = 32'h11;
        req1_valid = 1'b1; req1_addr = 4'd7; req1_data = 32'h22;
        step(); idle();
        repeat (5) step();
        got7 = 1'b0; first7 = '0;
        foreach (wlog[k]) if (wlog[k].a == 4'd7 && !got7) begin first7 = wlog[k].d; got7 = 1'b1; end
        chk("t4_first_r7", first7, 32'h11);
        chk("t4_final_r7", rf[7], 32'h22);
        chk("t4_nwrites", wlog.size(), 3);

        // Fill the load FIFO while the ALU keeps contending
        do_reset();
        wlog.delete();
        idx = 0;
        for (int c = 0; c < 4; c++) begin
            req0_valid = 1'b1; req0_addr = 4'd2; req0_data = $urandom;
            req1_valid = (idx < 3); req1_addr = 4'(8 + idx); req1_data = 32'h100 + 32'(idx);
            r1_seen[c] = req1_ready;
            if (req1_valid && req1_ready) idx++;
            step();
        end
        idle();
        chk("t5_ready_c0", r1_seen[0], 1'b1);
        chk("t5_ready_c1", r1_seen[1], 1'b1);
        chk("t5_ready_full", r1_seen[2], 1'b0);
        chk("t5_ready_freed", r1_seen[3], 1'b1);
        chk("t5_accepted", idx, 3);
        repeat (10) step();
        n10 = 0;
        foreach (wlog[k]) if (wlog[k].a == 4'd10) begin
            n10++;
            chk("t5_held_data", wlog[k].d, 32'h102);
        end
        chk("t5_held_written", n10, 1);

        // Reset while both FIFOs are full
        do_reset();
        for (int c = 0; c < 5; c++) begin
            req0_valid = 1'b1; req0_addr = 4'd11; req0_data = $urandom;
            req1_valid = 1'b1; req1_addr = 4'd12; req1_data = $urandom;
            step();
        end
        chk("t6_pre_mask", pending_mask, 16'h1800);
        rst = 1'b1; step(); step(); rst = 1'b0; idle();
        nwr = 0;
        for (int c = 0; c < 4; c++) begin
            if (reg_wr) nwr++;
            chk("t6_mask", pending_mask, 16'h0000);
            chk("t6_ready", {req0_ready, req1_ready}, 2'b11);
            step();
        end
        chk("t6_no_writes", nwr, 0);

        // Randomized traffic with frequent same-register collisions
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 249) == 0) begin
                rst = 1'b1; step(); step(); rst = 1'b0;
            end
            req0_valid = ($urandom_range(0, 3) != 0);
            req1_valid = ($urandom_range(0, 3) != 0);
            req0_addr  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 2));
            req1_addr  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 2));
            req0_data  = $urandom;
            req1_data  = $urandom;
            step();
        end
        idle();
        repeat (8) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
